// File: rtl/ib_loader_pkg.sv
// Shared encodings for the IB page loader: FSM states, write-function tags, page counts.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package ib_loader_pkg;

  // FSM state encoding
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_F0 = 3'd1;
  localparam logic [2:0] S_RD_F1 = 3'd2;
  localparam logic [2:0] S_RD_DN = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Target IB-RAM carried along with each in-flight ROM read
  localparam logic [1:0] FN_F0 = 2'd0;
  localparam logic [1:0] FN_F1 = 2'd1;
  localparam logic [1:0] FN_DN = 2'd2;

  // The RAM page port is one bit wider than the page address field
  function automatic int page_count(input int page_addr_bw);
    return 1 << (page_addr_bw + 1);
  endfunction

  // Page counts for the default geometry
  localparam int NP = page_count(6);
  localparam int ND = page_count(6);

endpackage

// File: rtl/ib_rom_align_pipe.sv
// Delay line that carries {valid, tag} alongside the IB-ROM read latency.
// Latency: DEPTH cycles from in_vld/in_tag to out_vld/out_tag.
// Backpressure: none; one entry accepted every cycle, reset empties the line.
module ib_rom_align_pipe #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_vld,
  output logic [TAG_W-1:0] out_tag
);

  logic [DEPTH-1:0] vld_q;
  logic [TAG_W-1:0] tag_q [DEPTH];

  // Shift valid and tag one stage per cycle; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
    end else begin
      vld_q[0] <= in_vld;
      tag_q[0] <= in_tag;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_tag = tag_q[DEPTH-1];

endmodule

// File: rtl/ib_page_loader.sv
// Streams one iteration's F0, F1 and DN IB tables from the IB-ROMs into the IB-RAMs.
// Latency: load_done pulses 2*NP + ND + ROM_RD_LATENCY + 1 cycles after load_start.
// Backpressure: none; load_start is taken only in IDLE, ignored while busy.
module ib_page_loader
  import ib_loader_pkg::*;
#(
  parameter int VN_ROM_RD_BW    = 8,
  parameter int VN_ROM_ADDR_BW  = 11,
  parameter int VN_PAGE_ADDR_BW = 6,
  parameter int DN_ROM_RD_BW    = 2,
  parameter int DN_ROM_ADDR_BW  = 11,
  parameter int DN_PAGE_ADDR_BW = 6,
  parameter int ROM_RD_LATENCY  = 2,
  parameter int MAX_ITER        = 8,
  parameter int ITER_BW         = 3
) (
  input  logic                       write_clk,
  input  logic                       rst,
  input  logic                       load_start,
  input  logic [ITER_BW-1:0]         iter_num,
  output logic [VN_ROM_ADDR_BW-1:0]  vn_rom_addr,
  output logic                       vn_rom_en,
  input  logic [VN_ROM_RD_BW-1:0]    vn_rom_data,
  output logic [DN_ROM_ADDR_BW-1:0]  dn_rom_addr,
  output logic                       dn_rom_en,
  input  logic [DN_ROM_RD_BW-1:0]    dn_rom_data,
  output logic [VN_PAGE_ADDR_BW:0]   page_addr_ram_0,
  output logic [VN_PAGE_ADDR_BW:0]   page_addr_ram_1,
  output logic [DN_PAGE_ADDR_BW:0]   page_addr_ram_2,
  output logic [VN_ROM_RD_BW-1:0]    ram_write_dataA_0,
  output logic [VN_ROM_RD_BW-1:0]    ram_write_dataA_1,
  output logic [DN_ROM_RD_BW-1:0]    ram_write_dataA_2,
  output logic [2:0]                 ib_ram_we,
  output logic                       busy,
  output logic                       load_done,
  output logic                       iter_err
);

  localparam int NPG   = page_count(VN_PAGE_ADDR_BW);
  localparam int NDG   = page_count(DN_PAGE_ADDR_BW);
  // One page counter serves all three phases, sized for the wider page space
  localparam int CW    = ((VN_PAGE_ADDR_BW > DN_PAGE_ADDR_BW) ? VN_PAGE_ADDR_BW : DN_PAGE_ADDR_BW) + 1;
  localparam int DCW   = (ROM_RD_LATENCY > 1) ? $clog2(ROM_RD_LATENCY) : 1;
  localparam int TAG_W = 2 + CW;

  localparam logic [CW-1:0]      VN_LAST    = CW'(NPG - 1);
  localparam logic [CW-1:0]      DN_LAST    = CW'(NDG - 1);
  localparam logic [CW-1:0]      PAGE_ONE   = CW'(1);
  localparam logic [DCW-1:0]     DRAIN_LAST = DCW'(ROM_RD_LATENCY - 1);
  localparam logic [DCW-1:0]     DRAIN_ONE  = DCW'(1);
  localparam logic [ITER_BW:0]   ITER_LIMIT = (ITER_BW + 1)'(MAX_ITER);

  logic [2:0]          state;
  logic [ITER_BW-1:0]  iter_q;
  logic [CW-1:0]       page_q;
  logic [DCW-1:0]      drain_q;
  logic                err_q;

  logic                rd_vn;
  logic                rd_dn;
  logic [1:0]          fn_cur;
  logic [31:0]         fn_off;

  logic                p_vld;
  logic [TAG_W-1:0]    p_tag;
  logic [1:0]          p_fn;
  logic [CW-1:0]       p_page;

  logic [VN_PAGE_ADDR_BW:0] pg0_q, pg1_q;
  logic [DN_PAGE_ADDR_BW:0] pg2_q;
  logic [VN_ROM_RD_BW-1:0]  d0_q, d1_q;
  logic [DN_ROM_RD_BW-1:0]  d2_q;

  // Sequencer: accept a request, walk F0/F1/DN pages, then wait out the ROM latency
  always_ff @(posedge write_clk) begin
    if (rst) begin
      state   <= S_IDLE;
      iter_q  <= '0;
      page_q  <= '0;
      drain_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_start) begin
            if ({1'b0, iter_num} < ITER_LIMIT) begin
              iter_q <= iter_num;
              page_q <= '0;
              state  <= S_RD_F0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_RD_F0: begin
          if (page_q == VN_LAST) begin
            page_q <= '0;
            state  <= S_RD_F1;
          end else begin
            page_q <= page_q + PAGE_ONE;
          end
        end
        S_RD_F1: begin
          if (page_q == VN_LAST) begin
            page_q <= '0;
            state  <= S_RD_DN;
          end else begin
            page_q <= page_q + PAGE_ONE;
          end
        end
        S_RD_DN: begin
          if (page_q == DN_LAST) begin
            page_q  <= '0;
            drain_q <= '0;
            state   <= S_DRAIN;
          end else begin
            page_q <= page_q + PAGE_ONE;
          end
        end
        S_DRAIN: begin
          if (drain_q == DRAIN_LAST) state <= S_DONE;
          else drain_q <= drain_q + DRAIN_ONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read-phase decode and the function tag that travels with each read
  always_comb begin
    rd_vn  = (state == S_RD_F0) || (state == S_RD_F1);
    rd_dn  = (state == S_RD_DN);
    fn_cur = FN_F0;
    fn_off = 32'd0;
    if (state == S_RD_F1) begin
      fn_cur = FN_F1;
      fn_off = 32'(NPG);
    end else if (state == S_RD_DN) begin
      fn_cur = FN_DN;
    end
  end

  // ROM addresses are truncated to the ROM width; outside a read phase they sit at 0
  assign vn_rom_en   = rd_vn;
  assign dn_rom_en   = rd_dn;
  assign vn_rom_addr = rd_vn ? VN_ROM_ADDR_BW'(32'(iter_q) * 32'(2 * NPG) + fn_off + 32'(page_q)) : '0;
  assign dn_rom_addr = rd_dn ? DN_ROM_ADDR_BW'(32'(iter_q) * 32'(NDG) + 32'(page_q)) : '0;

  ib_rom_align_pipe #(
    .DEPTH (ROM_RD_LATENCY),
    .TAG_W (TAG_W)
  ) u_align (
    .clk     (write_clk),
    .rst     (rst),
    .in_vld  (rd_vn | rd_dn),
    .in_tag  ({fn_cur, page_q}),
    .out_vld (p_vld),
    .out_tag (p_tag)
  );

  assign p_fn   = p_tag[TAG_W-1 -: 2];
  assign p_page = p_tag[CW-1:0];

  // Exactly one write enable per returning ROM word, chosen by its tag
  always_comb begin
    ib_ram_we = 3'b000;
    if (p_vld) begin
      case (p_fn)
        FN_F0:   ib_ram_we = 3'b001;
        FN_F1:   ib_ram_we = 3'b010;
        FN_DN:   ib_ram_we = 3'b100;
        default: ib_ram_we = 3'b000;
      endcase
    end
  end

  // Remember the last page/data written to each RAM so idle ports hold steady
  always_ff @(posedge write_clk) begin
    if (rst) begin
      pg0_q <= '0;
      pg1_q <= '0;
      pg2_q <= '0;
      d0_q  <= '0;
      d1_q  <= '0;
      d2_q  <= '0;
    end else begin
      if (ib_ram_we[0]) begin
        pg0_q <= p_page[VN_PAGE_ADDR_BW:0];
        d0_q  <= vn_rom_data;
      end
      if (ib_ram_we[1]) begin
        pg1_q <= p_page[VN_PAGE_ADDR_BW:0];
        d1_q  <= vn_rom_data;
      end
      if (ib_ram_we[2]) begin
        pg2_q <= p_page[DN_PAGE_ADDR_BW:0];
        d2_q  <= dn_rom_data;
      end
    end
  end

  // The selected port shows the live word in the same cycle as its write enable
  assign page_addr_ram_0   = ib_ram_we[0] ? p_page[VN_PAGE_ADDR_BW:0] : pg0_q;
  assign page_addr_ram_1   = ib_ram_we[1] ? p_page[VN_PAGE_ADDR_BW:0] : pg1_q;
  assign page_addr_ram_2   = ib_ram_we[2] ? p_page[DN_PAGE_ADDR_BW:0] : pg2_q;
  assign ram_write_dataA_0 = ib_ram_we[0] ? vn_rom_data : d0_q;
  assign ram_write_dataA_1 = ib_ram_we[1] ? vn_rom_data : d1_q;
  assign ram_write_dataA_2 = ib_ram_we[2] ? dn_rom_data : d2_q;

  assign busy      = (state != S_IDLE);
  assign load_done = (state == S_DONE);
  assign iter_err  = err_q;

endmodule
